// File: rtl/mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_pkg
// Shared constants for the multiply/divide unit: EX-stage op encodings,
// default multi-cycle latencies, controller state encoding and small decode
// helpers used by both the MDU controller and the instruction decoder.
// -----------------------------------------------------------------------------
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that start a multi-cycle operation (mult/multu/div/divu).
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op >= 3'(MD_MULT)) && (op <= 3'(MD_DIVU));
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == 3'(MD_DIV)) || (op == 3'(MD_DIVU));
    endfunction

    // Ops that touch HI/LO in any way; the decoder uses this to form md_use_D.
    function automatic logic md_use(input logic [2:0] op);
        return (op >= 3'(MD_MULT)) && (op <= 3'(MD_MTLO));
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Purely combinational multiply/divide datapath. The controller samples the
// result on the start edge and holds it until the latency has elapsed.
//
// Ports:
//   rs, rt       : operands (dividend/multiplicand, divisor/multiplier)
//   op           : md op encoding (only mult/multu/div/divu produce a result)
//   result       : {hi, lo} 64-bit result
//   div_by_zero  : div/divu with rt == 0; HI/LO must stay unchanged
// -----------------------------------------------------------------------------
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [2:0]  op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic signed [63:0] rs_x;
    logic signed [63:0] rt_x;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] rs_s;
    logic signed [31:0] div_s_rt;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] div_u_rt;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               rt_zero;
    logic               ovf;

    assign rs_x   = {{32{rs[31]}}, rs};
    assign rt_x   = {{32{rt[31]}}, rt};
    assign prod_s = rs_x * rt_x;
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    assign rt_zero = (rt == 32'd0);
    // The one signed quotient that does not fit in 32 bits.
    assign ovf     = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    // Substitute a harmless divisor for the zero and overflow cases so the
    // dividers never see them; those cases are resolved separately below.
    assign rs_s     = $signed(rs);
    assign div_s_rt = (rt_zero || ovf) ? 32'sd1 : $signed(rt);
    assign quot_s   = rs_s / div_s_rt;
    assign rem_s    = rs_s % div_s_rt;

    assign div_u_rt = rt_zero ? 32'd1 : rt;
    assign quot_u   = rs / div_u_rt;
    assign rem_u    = rs % div_u_rt;

    always_comb begin
        result = 64'd0;
        case (op)
            3'(MD_MULT):  result = prod_s;
            3'(MD_MULTU): result = prod_u;
            3'(MD_DIV):   result = ovf ? {32'd0, 32'h8000_0000} : {rem_s, quot_s};
            3'(MD_DIVU):  result = {rem_u, quot_u};
            default:      result = 64'd0;
        endcase
    end

    assign div_by_zero = md_is_div(op) && rt_zero;

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Multiply/divide controller in the EX stage. Sequences mult/multu/div/divu
// over a fixed latency, owns HI/LO, executes mthi/mtlo and requests a decode
// stall whenever a HI/LO-related instruction would collide with an operation
// in flight.
//
// Ports:
//   clk       : pipeline clock, rising edge
//   reset     : asynchronous, active-high; clears FSM, counter, HI/LO
//   md_op_E   : EX-stage op (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mthi, 6 mtlo, 7 reserved)
//   start_E   : qualifies md_op_E for ops 1-4
//   rs_E/rt_E : forwarded operands
//   md_use_D  : decode-stage instruction uses the MDU
//   busy      : multi-cycle operation in flight
//   stall_md  : freeze PC and IF/ID, bubble ID/EX
//   hi/lo     : architectural HI/LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op_E,
    input  logic        start_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pend_q;
    logic               pend_dbz_q;
    logic [63:0]        arith_res;
    logic               arith_dbz;
    logic               start_req;
    logic               launch;
    logic               commit;

    mdu_arith u_arith (
        .rs          (rs_E),
        .rt          (rt_E),
        .op          (md_op_E),
        .result      (arith_res),
        .div_by_zero (arith_dbz)
    );

    assign start_req = start_E && md_is_arith(md_op_E);
    // A start seen while running is dropped; the stall protocol keeps it from happening.
    assign launch    = start_req && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_RUN;
                    cnt_d   = md_is_div(md_op_E) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pending result is only meaningful while RUN; reset discards it by
    // returning the FSM to IDLE, so the data itself needs no reset.
    always_ff @(posedge clk) begin
        if (launch) begin
            pend_q     <= arith_res;
            pend_dbz_q <= arith_dbz;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            if (!pend_dbz_q) begin
                hi <= pend_q[63:32];
                lo <= pend_q[31:0];
            end
        end else if (state_q == ST_IDLE) begin
            if (md_op_E == 3'(MD_MTHI)) hi <= rs_E;
            if (md_op_E == 3'(MD_MTLO)) lo <= rs_E;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign stall_md = md_use_D && (busy || start_req);

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op_E;
    logic        start_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];
    logic [63:0] m_hilo;   // bench model of {hi, lo}

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op_E  (md_op_E),
        .start_E  (start_E),
        .rs_E     (rs_E),
        .rt_E     (rt_E),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: sign/magnitude division, independent of the RTL's approach.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [31:0]     ma, mb, uq, ur, q, r;
        case (op)
            3'(MD_MULT): begin
                sa = $signed(a);
                sb = $signed(b);
                return 64'(sa * sb);
            end
            3'(MD_MULTU): begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                return 64'(ua * ub);
            end
            3'(MD_DIV): begin
                if (b == 32'd0) return cur;
                ma = a[31] ? (32'd0 - a) : a;
                mb = b[31] ? (32'd0 - b) : b;
                uq = ma / mb;
                ur = ma % mb;
                q  = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
                r  = a[31] ? (32'd0 - ur) : ur;
                return {r, q};
            end
            3'(MD_DIVU): begin
                if (b == 32'd0) return cur;
                return {a % b, a / b};
            end
            default: return cur;
        endcase
    endfunction

    // Start one operation, follow the busy window, then score the result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input string tag);
        int          n;
        int          cyc;
        logic [63:0] hold;
        logic [63:0] exp;
        cyc = md_is_div(op) ? DC : MC;
        @(negedge clk);
        md_op_E  = op;
        start_E  = 1'b1;
        rs_E     = a;
        rt_E     = b;
        md_use_D = use_d;
        #1;
        check_eq({tag, "_stall_start"}, 64'(stall_md), 64'(use_d));
        exp    = ref_md(op, a, b, m_hilo);
        m_hilo = exp;
        sb_q.push_back(exp);
        hold = {hi, lo};
        @(posedge clk);
        #1;
        md_op_E = 3'(MD_NONE);
        start_E = 1'b0;
        rs_E    = $urandom;
        rt_E    = $urandom;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            n++;
            check_eq({tag, "_hold"}, {hi, lo}, hold);
            check_eq({tag, "_stall_busy"}, 64'(stall_md), 64'(use_d));
            @(negedge clk);
        end
        check_eq({tag, "_busy_len"}, 64'(n), 64'(cyc));
        check_eq({tag, "_stall_after"}, 64'(stall_md), 64'd0);
        if (sb_q.size() > 0) check_eq({tag, "_result"}, {hi, lo}, sb_q.pop_front());
        else check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
        md_use_D = 1'b0;
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] v, input logic st);
        @(negedge clk);
        md_op_E = op;
        start_E = st;
        rs_E    = v;
        @(posedge clk);
        #1;
        md_op_E = 3'(MD_NONE);
        start_E = 1'b0;
        if (op == 3'(MD_MTHI)) m_hilo[63:32] = v;
        if (op == 3'(MD_MTLO)) m_hilo[31:0]  = v;
        check_eq("mt_no_busy", 64'(busy), 64'd0);
        check_eq("mt_hilo", {hi, lo}, m_hilo);
    endtask

    initial begin
        reset    = 1'b1;
        md_op_E  = 3'(MD_NONE);
        start_E  = 1'b0;
        rs_E     = 32'd0;
        rt_E     = 32'd0;
        md_use_D = 1'b0;
        m_hilo   = 64'd0;
        #3;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        check_eq("rst_stall", 64'(stall_md), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'(MD_MULT), 32'hFFFF_FFFD, 32'd5, 1'b0, "mult");
        check_eq("mult_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        run_op(3'(MD_MULTU), 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        check_eq("multu_lit", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        run_op(3'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        check_eq("div_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        move_to(3'(MD_MTHI), 32'h11, 1'b0);
        move_to(3'(MD_MTLO), 32'h22, 1'b0);
        run_op(3'(MD_DIVU), 32'd7, 32'd0, 1'b0, "divu0");
        check_eq("divu0_lit", {hi, lo}, 64'h0000_0011_0000_0022);

        run_op(3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divovf");
        check_eq("divovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);

        // start_E together with mthi: op decides, no busy
        move_to(3'(MD_MTHI), 32'hCAFE_0001, 1'b1);
        // reserved op with start_E does nothing
        move_to(3'(MD_RSVD), 32'h1234_5678, 1'b1);

        // stall protocol with md_use_D held
        run_op(3'(MD_MULT), 32'd7, 32'd9, 1'b1, "stallmult");

        for (int i = 0; i < 4; i++) begin
            run_op(3'(1 + (i % 4)), $urandom, $urandom, 1'(i % 2), "rnd");
        end

        // asynchronous reset three cycles into a div
        @(negedge clk);
        md_op_E = 3'(MD_DIV);
        start_E = 1'b1;
        rs_E    = 32'd100;
        rt_E    = 32'd3;
        @(posedge clk);
        #1;
        md_op_E = 3'(MD_NONE);
        start_E = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_hilo", {hi, lo}, 64'd0);
        m_hilo = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (DC + 2) @(negedge clk);
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_eq("post_rst_nocommit", {hi, lo}, 64'd0);

        run_op(3'(MD_MULT), 32'd1000, 32'hFFFF_FFFE, 1'b0, "mult_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
